lcd_bus_receiver: RTL and testbench

Receive side of the 8-bit 8080-style write bus (`wr`, `dcx`, `D`) that the image generator drives toward the LCD. The block is a synthesizable panel model. It decodes command and data bytes, tracks the column/page address window, and assembles RGB565 pixels with their x/y coordinates. It sits beside `image_generator` on the same clock and is used for on-chip self-check and for the verification framebuffer monitor.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/bus_sync_edge.sv | 60 ++++++
 rtl/lcd_bus_receiver.sv | 236 +++++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD write-bus receiver.
//   - command codes of the 8080-style panel protocol
//   - receiver FSM state encoding
//   - default panel size and the helper that derives the default window ends
package lcd_pkg;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam int DEF_WIDTH  = 240;
  localparam int DEF_HEIGHT = 320;

  // Every window starts at 0 after reset / SWRESET.
  localparam logic [15:0] WIN_FIRST = 16'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_ARG,
    ST_PASET_ARG,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_DISCARD
  } state_t;

  // Last valid index of a panel dimension (default window end).
  function automatic logic [15:0] win_last(input int unsigned extent);
    return 16'(extent - 1);
  endfunction

endpackage

// File: rtl/bus_sync_edge.sv
// bus_sync_edge: STAGES-deep synchronizer for the {wr, dcx, D} bus plus a
// registered rising-edge strobe for wr. The byte and dcx outputs are captured
// on the same clock as the strobe so they are aligned with it.
// Ports:
//   clk, nrst      clock, asynchronous active-low reset
//   wr_in, dcx_in  raw bus strobe / data-command select
//   d_in[7:0]      raw bus byte
//   stb            one-clk pulse per wr rising edge
//   dcx, d[7:0]    byte qualifiers valid with stb
module bus_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       wr_in,
  input  logic       dcx_in,
  input  logic [7:0] d_in,
  output logic       stb,
  output logic       dcx,
  output logic [7:0] d
);

  // Bundle layout: [9] wr, [8] dcx, [7:0] D. wr resets high so leaving reset
  // with an idle (high) bus creates no false edge.
  localparam logic [9:0] SYNC_RST = 10'h200;

  logic [9:0] sync_reg [STAGES];
  logic       wr_prev_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) sync_reg[gi] <= SYNC_RST;
          else       sync_reg[gi] <= {wr_in, dcx_in, d_in};
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) sync_reg[gi] <= SYNC_RST;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_prev_reg <= 1'b1;
      stb         <= 1'b0;
      dcx         <= 1'b0;
      d           <= 8'h00;
    end else begin
      wr_prev_reg <= sync_reg[STAGES-1][9];
      stb         <= sync_reg[STAGES-1][9] & ~wr_prev_reg;
      dcx         <= sync_reg[STAGES-1][8];
      d           <= sync_reg[STAGES-1][7:0];
    end
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: panel-side model of the 8080 write bus. Decodes command
// and data bytes, keeps the column/page window, and assembles RGB565 pixels
// with coordinates.
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   wr, dcx, D[7:0]            raw write bus
//   cmd_valid, cmd_code[7:0]   command pulse / last command byte
//   pix_valid, pix_x, pix_y,
//   pix_data[15:0]             pixel pulse with coordinates and colour
//   frame_done                 pulse with the pixel at (EC, EP)
//   win_err                    pulse when CASET/PASET has start > end
//   disp_on, sleep_out         status levels
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wr,
  input  logic        dcx,
  input  logic [7:0]  D,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        win_err,
  output logic        disp_on,
  output logic        sleep_out
);

  localparam logic [15:0] DEF_EC = win_last(WIDTH);
  localparam logic [15:0] DEF_EP = win_last(HEIGHT);

  logic       sync_stb, sync_dcx;
  logic [7:0] sync_d;

  bus_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .nrst   (nrst),
    .wr_in  (wr),
    .dcx_in (dcx),
    .d_in   (D),
    .stb    (sync_stb),
    .dcx    (sync_dcx),
    .d      (sync_d)
  );

  // Input capture stage between the synchronizer and the decoder; it sets the
  // strobe-to-output latency at SYNC_STAGES+2 clocks.
  logic       in_stb_reg, in_dcx_reg;
  logic [7:0] in_byte_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      in_stb_reg  <= 1'b0;
      in_dcx_reg  <= 1'b0;
      in_byte_reg <= 8'h00;
    end else begin
      in_stb_reg  <= sync_stb;
      in_dcx_reg  <= sync_dcx;
      in_byte_reg <= sync_d;
    end
  end

  state_t      state_reg, state_next;
  logic [1:0]  arg_cnt_reg, arg_cnt_next;
  logic [23:0] arg_buf_reg, arg_buf_next;   // start hi, start lo, end hi
  logic [15:0] sc_reg, sc_next, ec_reg, ec_next;
  logic [15:0] sp_reg, sp_next, ep_reg, ep_next;
  logic [15:0] x_reg, x_next, y_reg, y_next;
  logic [7:0]  hi_reg, hi_next;
  logic        cmd_valid_next, pix_valid_next, frame_done_next, win_err_next;
  logic        disp_on_next, sleep_out_next;
  logic [7:0]  cmd_code_next;
  logic [15:0] pix_x_next, pix_y_next, pix_data_next;
  logic [15:0] arg_start, arg_end;

  assign arg_start = arg_buf_reg[23:8];
  assign arg_end   = {arg_buf_reg[7:0], in_byte_reg};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= ST_IDLE;
      arg_cnt_reg <= 2'd0;
      arg_buf_reg <= 24'h0;
      sc_reg      <= WIN_FIRST;
      ec_reg      <= DEF_EC;
      sp_reg      <= WIN_FIRST;
      ep_reg      <= DEF_EP;
      x_reg       <= 16'h0;
      y_reg       <= 16'h0;
      hi_reg      <= 8'h00;
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
      pix_valid   <= 1'b0;
      pix_x       <= 16'h0;
      pix_y       <= 16'h0;
      pix_data    <= 16'h0;
      frame_done  <= 1'b0;
      win_err     <= 1'b0;
      disp_on     <= 1'b0;
      sleep_out   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      arg_cnt_reg <= arg_cnt_next;
      arg_buf_reg <= arg_buf_next;
      sc_reg      <= sc_next;
      ec_reg      <= ec_next;
      sp_reg      <= sp_next;
      ep_reg      <= ep_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      hi_reg      <= hi_next;
      cmd_valid   <= cmd_valid_next;
      cmd_code    <= cmd_code_next;
      pix_valid   <= pix_valid_next;
      pix_x       <= pix_x_next;
      pix_y       <= pix_y_next;
      pix_data    <= pix_data_next;
      frame_done  <= frame_done_next;
      win_err     <= win_err_next;
      disp_on     <= disp_on_next;
      sleep_out   <= sleep_out_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    arg_cnt_next    = arg_cnt_reg;
    arg_buf_next    = arg_buf_reg;
    sc_next         = sc_reg;
    ec_next         = ec_reg;
    sp_next         = sp_reg;
    ep_next         = ep_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    hi_next         = hi_reg;
    cmd_valid_next  = 1'b0;
    cmd_code_next   = cmd_code;
    pix_valid_next  = 1'b0;
    pix_x_next      = pix_x;
    pix_y_next      = pix_y;
    pix_data_next   = pix_data;
    frame_done_next = 1'b0;
    win_err_next    = 1'b0;
    disp_on_next    = disp_on;
    sleep_out_next  = sleep_out;

    if (in_stb_reg && !in_dcx_reg) begin
      // A command always aborts whatever was in progress, including a
      // half-received pixel or window argument list.
      cmd_valid_next = 1'b1;
      cmd_code_next  = in_byte_reg;
      state_next     = ST_IDLE;
      case (in_byte_reg)
        CMD_SWRESET: begin
          sc_next        = WIN_FIRST;
          ec_next        = DEF_EC;
          sp_next        = WIN_FIRST;
          ep_next        = DEF_EP;
          disp_on_next   = 1'b0;
          sleep_out_next = 1'b0;
        end
        CMD_NOP:     ;
        CMD_SLPIN:   sleep_out_next = 1'b0;
        CMD_SLPOUT:  sleep_out_next = 1'b1;
        CMD_DISPOFF: disp_on_next   = 1'b0;
        CMD_DISPON:  disp_on_next   = 1'b1;
        CMD_CASET: begin
          state_next   = ST_CASET_ARG;
          arg_cnt_next = 2'd0;
        end
        CMD_PASET: begin
          state_next   = ST_PASET_ARG;
          arg_cnt_next = 2'd0;
        end
        CMD_RAMWR: begin
          state_next = ST_RAMWR_HI;
          x_next     = sc_reg;
          y_next     = sp_reg;
        end
        default:     state_next = ST_DISCARD;
      endcase
    end else if (in_stb_reg) begin
      case (state_reg)
        ST_CASET_ARG, ST_PASET_ARG: begin
          if (arg_cnt_reg != 2'd3) begin
            arg_buf_next = {arg_buf_reg[15:0], in_byte_reg};
            arg_cnt_next = arg_cnt_reg + 2'd1;
          end else begin
            if (arg_start > arg_end) begin
              win_err_next = 1'b1;
            end else if (state_reg == ST_CASET_ARG) begin
              sc_next = arg_start;
              ec_next = arg_end;
            end else begin
              sp_next = arg_start;
              ep_next = arg_end;
            end
            state_next = ST_DISCARD;
          end
        end
        ST_RAMWR_HI: begin
          hi_next    = in_byte_reg;
          state_next = ST_RAMWR_LO;
        end
        ST_RAMWR_LO: begin
          pix_valid_next = 1'b1;
          pix_x_next     = x_reg;
          pix_y_next     = y_reg;
          pix_data_next  = {hi_reg, in_byte_reg};
          state_next     = ST_RAMWR_HI;
          if (x_reg == ec_reg) begin
            x_next = sc_reg;
            if (y_reg == ep_reg) begin
              y_next          = sp_reg;
              frame_done_next = 1'b1;
            end else begin
              y_next = y_reg + 16'd1;
            end
          end else begin
            x_next = x_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: directed self-checking bench for lcd_bus_receiver.
// A negedge monitor logs every pixel / command / window-error pulse; the main
// sequence compares the log and the status outputs against hand-computed values.
module tb_lcd_bus_receiver;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        wr = 1'b1;
  logic        dcx = 1'b0;
  logic [7:0]  D = 8'h00;
  logic        cmd_valid, pix_valid, frame_done, win_err, disp_on, sleep_out;
  logic [7:0]  cmd_code;
  logic [15:0] pix_x, pix_y, pix_data;

  lcd_bus_receiver #(.WIDTH(240), .HEIGHT(320), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .wr         (wr),
    .dcx        (dcx),
    .D          (D),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .frame_done (frame_done),
    .win_err    (win_err),
    .disp_on    (disp_on),
    .sleep_out  (sleep_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor
  logic [15:0] px_q[$];
  logic [15:0] py_q[$];
  logic [15:0] pd_q[$];
  logic        fd_q[$];
  int          cmd_cnt = 0;
  int          err_cnt = 0;

  always @(negedge clk) begin
    if (nrst) begin
      if (pix_valid) begin
        px_q.push_back(pix_x);
        py_q.push_back(pix_y);
        pd_q.push_back(pix_data);
        fd_q.push_back(frame_done);
        $display("[TB] pix (%0d,%0d) data=%04h frame_done=%0b", pix_x, pix_y, pix_data, frame_done);
      end
      if (cmd_valid) begin
        cmd_cnt++;
        $display("[TB] cmd %02h", cmd_code);
      end
      if (win_err) begin
        err_cnt++;
        $display("[TB] win_err");
      end
    end
  end

  // One bus write at maximum throughput: wr low 3 clk, high 3 clk.
  task automatic send(input logic c, input logic [7:0] b);
    @(negedge clk);
    wr = 1'b0; dcx = c; D = b;
    repeat (3) @(negedge clk);
    wr = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_pix(input logic [15:0] p);
    send(1'b1, p[15:8]);
    send(1'b1, p[7:0]);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  int ex_x [6] = '{5, 6, 7, 5, 6, 7};
  int ex_y [6] = '{2, 2, 2, 3, 3, 3};
  int base;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_code", 32'(cmd_code), 32'h0);
    check_eq("rst_pix_valid", 32'(pix_valid), 32'h0);
    check_eq("rst_pix_x", 32'(pix_x), 32'h0);
    check_eq("rst_pix_y", 32'(pix_y), 32'h0);
    check_eq("rst_pix_data", 32'(pix_data), 32'h0);
    check_eq("rst_disp_on", 32'(disp_on), 32'h0);
    check_eq("rst_sleep_out", 32'(sleep_out), 32'h0);
    nrst = 1'b1;
    settle();
    check_eq("rst_no_false_edge", 32'(cmd_cnt), 32'd0);

    // Window 5..7 x 2..3, six red pixels
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h07);
    send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h02); send(1'b1, 8'h00); send(1'b1, 8'h03);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 6; i++) send_pix(16'hF800);
    settle();
    check_eq("t1_pix_count", 32'(px_q.size()), 32'd6);
    check_eq("t1_cmd_count", 32'(cmd_cnt), 32'd3);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t1_x%0d", i), 32'(px_q[i]), 32'(ex_x[i]));
      check_eq($sformatf("t1_y%0d", i), 32'(py_q[i]), 32'(ex_y[i]));
      check_eq($sformatf("t1_d%0d", i), 32'(pd_q[i]), 32'hF800);
      check_eq($sformatf("t1_fd%0d", i), 32'(fd_q[i]), (i == 5) ? 32'd1 : 32'd0);
    end

    // Seventh pixel wraps to (SC,SP)
    send_pix(16'h07E0);
    settle();
    check_eq("t2_pix_count", 32'(px_q.size()), 32'd7);
    check_eq("t2_x", 32'(px_q[6]), 32'd5);
    check_eq("t2_y", 32'(py_q[6]), 32'd2);
    check_eq("t2_d", 32'(pd_q[6]), 32'h07E0);
    check_eq("t2_fd", 32'(fd_q[6]), 32'd0);

    // Rejected window (start > end)
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h0A); send(1'b1, 8'h00); send(1'b1, 8'h04);
    settle();
    check_eq("t3_win_err_count", 32'(err_cnt), 32'd1);
    send(1'b0, 8'h2C);
    send_pix(16'h001F);
    settle();
    check_eq("t3_x_retained", 32'(px_q[7]), 32'd5);
    check_eq("t3_y_retained", 32'(py_q[7]), 32'd2);

    // Dangling HI byte aborted by DISPON
    base = px_q.size();
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    send(1'b0, 8'h29);
    settle();
    check_eq("t4_no_pix", 32'(px_q.size()), 32'(base));
    check_eq("t4_cmd_code", 32'(cmd_code), 32'h29);
    check_eq("t4_disp_on", 32'(disp_on), 32'd1);
    send(1'b0, 8'h11);
    settle();
    check_eq("t4_sleep_out", 32'(sleep_out), 32'd1);
    send(1'b0, 8'h01);
    settle();
    check_eq("t4_swreset_disp", 32'(disp_on), 32'd0);
    check_eq("t4_swreset_sleep", 32'(sleep_out), 32'd0);

    // Default column window 0..239
    base = px_q.size();
    send(1'b0, 8'h2C);
    for (int i = 0; i < 241; i++) send_pix(16'(i));
    settle();
    check_eq("t5_count", 32'(px_q.size()), 32'(base + 241));
    check_eq("t5_first_x", 32'(px_q[base]), 32'd0);
    check_eq("t5_first_y", 32'(py_q[base]), 32'd0);
    check_eq("t5_col239_x", 32'(px_q[base+239]), 32'd239);
    check_eq("t5_col239_y", 32'(py_q[base+239]), 32'd0);
    check_eq("t5_col239_fd", 32'(fd_q[base+239]), 32'd0);
    check_eq("t5_wrap_x", 32'(px_q[base+240]), 32'd0);
    check_eq("t5_wrap_y", 32'(py_q[base+240]), 32'd1);
    check_eq("t5_wrap_d", 32'(pd_q[base+240]), 32'd240);

    // Default page window 0..319, single column
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h00);
    base = px_q.size();
    send(1'b0, 8'h2C);
    for (int i = 0; i < 321; i++) send_pix(16'h5555);
    settle();
    check_eq("t6_count", 32'(px_q.size()), 32'(base + 321));
    check_eq("t6_row318_fd", 32'(fd_q[base+318]), 32'd0);
    check_eq("t6_row319_y", 32'(py_q[base+319]), 32'd319);
    check_eq("t6_row319_x", 32'(px_q[base+319]), 32'd0);
    check_eq("t6_row319_fd", 32'(fd_q[base+319]), 32'd1);
    check_eq("t6_wrap_y", 32'(py_q[base+320]), 32'd0);

    // Latency: wr rising sampled at edge N -> cmd_valid only at N+4
    base = cmd_cnt;
    @(negedge clk);
    wr = 1'b0; dcx = 1'b0; D = 8'h00;
    repeat (4) @(negedge clk);
    wr = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("lat_edge%0d", k), 32'(cmd_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    settle();
    check_eq("lat_one_pulse", 32'(cmd_cnt), 32'(base + 1));

    // Reset between HI and LO of a pixel
    send(1'b0, 8'h29);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h12);
    settle();
    base = px_q.size();
    #2 nrst = 1'b0;
    #1;
    check_eq("arst_pix_valid", 32'(pix_valid), 32'd0);
    check_eq("arst_cmd_code", 32'(cmd_code), 32'd0);
    check_eq("arst_disp_on", 32'(disp_on), 32'd0);
    check_eq("arst_pix_x", 32'(pix_x), 32'd0);
    check_eq("arst_pix_y", 32'(pix_y), 32'd0);
    check_eq("arst_pix_data", 32'(pix_data), 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    settle();
    check_eq("arst_no_pix", 32'(px_q.size()), 32'(base));
    send(1'b0, 8'h2C);
    send_pix(16'h1234);
    settle();
    check_eq("arst_next_count", 32'(px_q.size()), 32'(base + 1));
    check_eq("arst_next_x", 32'(px_q[base]), 32'd0);
    check_eq("arst_next_y", 32'(py_q[base]), 32'd0);
    check_eq("arst_next_d", 32'(pd_q[base]), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
